// File: rtl/bp_me_cache_pkt_arbiter_pkg.sv
// Shared types and width helpers for the cache packet arbiter.
package bp_me_cache_pkt_arbiter_pkg;

   localparam int unsigned cache_opcode_width_lp = 6;

   typedef enum logic {e_arb_free, e_arb_locked} bp_me_cache_arb_state_e;

   function automatic int unsigned arb_id_width(input int unsigned num_req);
      return (num_req <= 1) ? 1 : $clog2(num_req);
   endfunction

   // Matches bsg_cache_pkt layout: {opcode, addr, data, byte mask}
   function automatic int unsigned cache_pkt_width(input int unsigned caddr_width,
                                                   input int unsigned data_width);
      return cache_opcode_width_lp + caddr_width + data_width + data_width / 8;
   endfunction

endpackage

// File: rtl/bp_me_cache_arb_id_fifo.sv
// In-order requester ID FIFO with asynchronous active-low reset.
module bp_me_cache_arb_id_fifo #(
   parameter int unsigned width_p = 1,
   parameter int unsigned els_p   = 4
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] data_i,
   input  logic               v_i,
   input  logic               yumi_i,
   output logic               full_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o
);

   localparam int unsigned ptr_width_lp = (els_p <= 1) ? 1 : $clog2(els_p);
   localparam int unsigned cnt_width_lp = $clog2(els_p + 1);

   logic [width_p-1:0]      mem_r [els_p];
   logic [ptr_width_lp-1:0] wptr_r, rptr_r;
   logic [cnt_width_lp-1:0] cnt_r;
   logic                    push, pop;

   assign full_o = (cnt_r == cnt_width_lp'(els_p));
   assign v_o    = (cnt_r != '0);
   assign data_o = mem_r[rptr_r];
   assign push   = v_i & ~full_o;
   assign pop    = yumi_i & v_o;

   function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
      return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_r <= '0;
         rptr_r <= '0;
         cnt_r  <= '0;
      end else begin
         if (push) wptr_r <= ptr_inc(wptr_r);
         if (pop)  rptr_r <= ptr_inc(rptr_r);
         cnt_r <= cnt_r + cnt_width_lp'(push) - cnt_width_lp'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_r[wptr_r] <= data_i;
   end

endmodule

// File: rtl/bp_me_cache_pkt_arbiter.sv
// Round-robin arbiter sharing one bsg_cache among several packet requesters,
// with per-packet lock and in-order response steering.
module bp_me_cache_pkt_arbiter
   import bp_me_cache_pkt_arbiter_pkg::*;
#(
   parameter int unsigned caddr_width_p   = 32,
   parameter int unsigned l2_data_width_p = 64,
   parameter int unsigned num_req_p       = 2,
   parameter int unsigned id_fifo_els_p   = 4,
   localparam int unsigned pkt_width_lp   = cache_pkt_width(caddr_width_p, l2_data_width_p)
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic [num_req_p*pkt_width_lp-1:0] req_pkt_i,
   input  logic [num_req_p-1:0]              req_v_i,
   input  logic [num_req_p-1:0]              req_lock_i,
   output logic [num_req_p-1:0]              req_ready_and_o,
   output logic [l2_data_width_p-1:0]        resp_data_o,
   output logic [num_req_p-1:0]              resp_v_o,
   input  logic [num_req_p-1:0]              resp_yumi_i,
   output logic [pkt_width_lp-1:0]           cache_pkt_o,
   output logic                              v_o,
   input  logic                              ready_i,
   input  logic [l2_data_width_p-1:0]        data_i,
   input  logic                              v_i,
   output logic                              yumi_o
);

   localparam int unsigned id_width_lp = arb_id_width(num_req_p);

   bp_me_cache_arb_state_e  state_r, state_n;
   logic [id_width_lp-1:0]  rr_r, rr_n, owner_r, owner_n;
   logic [id_width_lp-1:0]  grant_id, cand, head_id;
   logic                    grant_v, issue_ok, hs;
   logic                    fifo_full, fifo_v;
   logic [pkt_width_lp-1:0] pkt_a [num_req_p];

   always_comb begin
      for (int unsigned i = 0; i < num_req_p; i++)
         pkt_a[i] = req_pkt_i[i*pkt_width_lp +: pkt_width_lp];
   end

   always_comb begin
      grant_v  = 1'b0;
      grant_id = '0;
      cand     = '0;
      if (state_r == e_arb_locked) begin
         grant_v  = req_v_i[owner_r];
         grant_id = owner_r;
      end else begin
         for (int unsigned i = 0; i < num_req_p; i++) begin
            cand = id_width_lp'((32'(rr_r) + i) % num_req_p);
            if (!grant_v && req_v_i[cand]) begin
               grant_v  = 1'b1;
               grant_id = cand;
            end
         end
      end
   end

   // Reset gating keeps issue outputs quiet while reset_n_i is low, even mid-cycle
   assign issue_ok    = reset_n_i & grant_v & ~fifo_full;
   assign v_o         = issue_ok;
   assign hs          = issue_ok & ready_i;
   assign cache_pkt_o = grant_v ? pkt_a[grant_id] : '0;

   always_comb begin
      req_ready_and_o = '0;
      for (int unsigned i = 0; i < num_req_p; i++)
         req_ready_and_o[i] = hs & (grant_id == id_width_lp'(i));
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= e_arb_free;
         rr_r    <= '0;
         owner_r <= '0;
      end else begin
         state_r <= state_n;
         rr_r    <= rr_n;
         owner_r <= owner_n;
      end
   end

   always_comb begin
      state_n = state_r;
      rr_n    = rr_r;
      owner_n = owner_r;
      if (hs) begin
         rr_n = (grant_id == id_width_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
         if (req_lock_i[grant_id]) begin
            state_n = e_arb_locked;
            owner_n = grant_id;
         end else begin
            state_n = e_arb_free;
         end
      end
   end

   bp_me_cache_arb_id_fifo #(
      .width_p (id_width_lp),
      .els_p   (id_fifo_els_p)
   ) id_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (grant_id),
      .v_i       (hs),
      .yumi_i    (yumi_o),
      .full_o    (fifo_full),
      .v_o       (fifo_v),
      .data_o    (head_id)
   );

   always_comb begin
      resp_v_o = '0;
      for (int unsigned i = 0; i < num_req_p; i++)
         resp_v_o[i] = v_i & fifo_v & (head_id == id_width_lp'(i));
   end

   assign resp_data_o = data_i;
   assign yumi_o      = |(resp_v_o & resp_yumi_i);

   resp_without_pending_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(v_i && !fifo_v));
   yumi_without_valid_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (resp_yumi_i & ~resp_v_o) == '0);

endmodule

// File: tb/tb_bp_me_cache_pkt_arbiter.sv
// Randomized and directed checks of the cache packet arbiter against a queue-based model.
module tb_bp_me_cache_pkt_arbiter;

   localparam int unsigned N   = 2;
   localparam int unsigned AW  = 8;
   localparam int unsigned DW  = 8;
   localparam int unsigned PW  = 6 + AW + DW + DW / 8;
   localparam int unsigned ELS = 4;

   logic            clk_i = 1'b0;
   logic            reset_n_i;
   logic [N*PW-1:0] req_pkt_i;
   logic [N-1:0]    req_v_i, req_lock_i, req_ready_and_o, resp_v_o, resp_yumi_i;
   logic [DW-1:0]   resp_data_o, data_i;
   logic [PW-1:0]   cache_pkt_o;
   logic            v_o, ready_i, v_i, yumi_o;

   bp_me_cache_pkt_arbiter #(
      .caddr_width_p   (AW),
      .l2_data_width_p (DW),
      .num_req_p       (N),
      .id_fifo_els_p   (ELS)
   ) dut (
      .clk_i           (clk_i),
      .reset_n_i       (reset_n_i),
      .req_pkt_i       (req_pkt_i),
      .req_v_i         (req_v_i),
      .req_lock_i      (req_lock_i),
      .req_ready_and_o (req_ready_and_o),
      .resp_data_o     (resp_data_o),
      .resp_v_o        (resp_v_o),
      .resp_yumi_i     (resp_yumi_i),
      .cache_pkt_o     (cache_pkt_o),
      .v_o             (v_o),
      .ready_i         (ready_i),
      .data_i          (data_i),
      .v_i             (v_i),
      .yumi_o          (yumi_o)
   );

   always #5 clk_i = ~clk_i;

   // model state
   int            m_rr, m_owner;
   bit            m_locked;
   int            idq[$];
   logic [DW-1:0] cq_data[$];
   int            cq_due[$];
   int            cyc;
   logic [PW-1:0] pkt_a [N];
   int            hold_resp, yumi_mode, last_hs;
   logic [N-1:0]  snap_ready, snap_respv;
   logic          snap_v, snap_yumi;
   int            checks, errors;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int model_grant();
      if (m_locked) return req_v_i[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_rr + k) % N;
         if (req_v_i[j]) return j;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      m_rr = 0; m_owner = 0; m_locked = 0;
      idq.delete(); cq_data.delete(); cq_due.delete();
   endfunction

   task automatic set_req(input logic [N-1:0] v, input logic [N-1:0] lock, input logic rdy);
      req_v_i = v; req_lock_i = lock; ready_i = rdy;
      for (int i = 0; i < N; i++) pkt_a[i] = PW'($urandom);
   endtask

   // One clock: drive cache side, check against model at negedge+1, advance model at posedge
   task automatic cycle();
      int            g;
      bit            full, hs;
      logic [N-1:0]  e_ready, e_respv;
      logic          e_yumi;
      logic [PW-1:0] e_pkt;
      for (int i = 0; i < N; i++) req_pkt_i[i*PW +: PW] = pkt_a[i];
      v_i    = (hold_resp == 0) && (cq_due.size() > 0) && (cq_due[0] <= cyc);
      data_i = v_i ? cq_data[0] : DW'($urandom);
      e_respv = '0;
      if (v_i && idq.size() > 0) e_respv[idq[0]] = 1'b1;
      case (yumi_mode)
         0:       resp_yumi_i = '0;
         1:       resp_yumi_i = e_respv;
         default: resp_yumi_i = e_respv & N'($urandom);
      endcase
      #1;
      g     = model_grant();
      full  = (idq.size() == ELS);
      e_pkt = (g >= 0) ? pkt_a[g] : '0;
      hs    = (g >= 0) && !full && ready_i;
      e_ready = '0;
      if (hs) e_ready[g] = 1'b1;
      e_yumi = |(e_respv & resp_yumi_i);
      chk("v_o", v_o, (g >= 0) && !full);
      chk("cache_pkt_o", cache_pkt_o, e_pkt);
      chk("req_ready_and_o", req_ready_and_o, e_ready);
      chk("resp_v_o", resp_v_o, e_respv);
      chk("yumi_o", yumi_o, e_yumi);
      if (e_respv != '0) chk("resp_data_o", resp_data_o, cq_data[0]);
      snap_ready = req_ready_and_o; snap_respv = resp_v_o;
      snap_v = v_o; snap_yumi = yumi_o;
      last_hs = hs ? g : -1;
      @(posedge clk_i);
      if (e_yumi) begin
         void'(idq.pop_front()); void'(cq_data.pop_front()); void'(cq_due.pop_front());
      end
      if (hs) begin
         idq.push_back(g);
         cq_data.push_back(pkt_a[g][PW-7 -: AW]);
         cq_due.push_back(cyc + 3);
         m_rr     = (g + 1) % N;
         m_locked = req_lock_i[g];
         m_owner  = g;
      end
      cyc++;
      @(negedge clk_i);
   endtask

   task automatic drain();
      set_req('0, '0, 1'b1);
      hold_resp = 0; yumi_mode = 1;
      for (int t = 0; t < 30 && idq.size() > 0; t++) cycle();
      chk("drain_bound", idq.size(), 0);
   endtask

   initial begin
      logic [N-1:0] rr_exp [4];
      int           sent0, n1_after, hs_cnt;
      checks = 0; errors = 0; cyc = 0; last_hs = -1;
      hold_resp = 0; yumi_mode = 1;
      model_reset();
      reset_n_i = 1'b0; req_pkt_i = '0; req_v_i = '0; req_lock_i = '0;
      resp_yumi_i = '0; ready_i = 1'b0; data_i = '0; v_i = 1'b0;

      // outputs quiet in reset even with requests pending
      #2 req_v_i = 2'b11; ready_i = 1'b1;
      #1;
      chk("reset_v_o", v_o, 0);
      chk("reset_ready", req_ready_and_o, 0);
      chk("reset_resp_v", resp_v_o, 0);
      chk("reset_yumi", yumi_o, 0);
      req_v_i = '0;
      @(negedge clk_i); #1 reset_n_i = 1'b1;
      @(negedge clk_i);

      // round robin from pointer 0
      rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
      for (int i = 0; i < 4; i++) begin
         set_req(2'b11, 2'b00, 1'b1);
         cycle();
         chk("rr_grant", snap_ready, rr_exp[i]);
      end
      drain();

      // lock keeps requester 0 contiguous for 8 packets
      sent0 = 0; n1_after = 0;
      for (int t = 0; t < 60 && sent0 < 8; t++) begin
         set_req(2'b11, {1'b0, sent0 < 7}, 1'b1);
         cycle();
         if (last_hs == 0) sent0++;
         else if (last_hs == 1 && sent0 > 0) n1_after++;
      end
      chk("lock_count0", sent0, 8);
      chk("lock_no_interleave", n1_after, 0);
      last_hs = -1;
      for (int t = 0; t < 20 && last_hs < 0; t++) begin
         set_req(2'b11, 2'b00, 1'b1);
         cycle();
      end
      chk("lock_release_to_1", snap_ready, 2'b10);
      drain();

      // full FIFO: 4 accepted, 5th only the cycle after a pop
      hold_resp = 1; hs_cnt = 0;
      for (int t = 0; t < 6; t++) begin
         set_req(2'b11, 2'b00, 1'b1);
         cycle();
         if (snap_ready != '0) hs_cnt++;
      end
      chk("full_hs_count", hs_cnt, 4);
      chk("full_ready_low", snap_ready, 0);
      hold_resp = 0;
      set_req(2'b11, 2'b00, 1'b1);
      cycle();
      chk("full_pop_yumi", snap_yumi, 1);
      chk("full_no_same_cycle_push", snap_ready, 0);
      hold_resp = 1;
      set_req(2'b11, 2'b00, 1'b1);
      cycle();
      chk("full_next_cycle_push", snap_ready != '0, 1);
      drain();

      // head ID 1 held without consumption
      set_req(2'b10, 2'b00, 1'b1);
      cycle();
      chk("head1_issue", snap_ready, 2'b10);
      yumi_mode = 0;
      for (int t = 0; t < 4; t++) begin
         set_req(2'b00, 2'b00, 1'b1);
         cycle();
         if (t >= 2) begin
            chk("head1_resp_v", snap_respv, 2'b10);
            chk("head1_no_yumi", snap_yumi, 0);
         end
      end
      yumi_mode = 1;
      cycle();
      chk("head1_pop", snap_yumi, 1);
      drain();

      // locked owner drops valid: nobody else may issue
      set_req(2'b01, 2'b01, 1'b1);
      cycle();
      chk("drop_lock_issue", snap_ready, 2'b01);
      for (int t = 0; t < 3; t++) begin
         set_req(2'b10, 2'b00, 1'b1);
         cycle();
         chk("drop_no_grant", snap_v, 0);
      end
      set_req(2'b11, 2'b00, 1'b1);
      cycle();
      chk("drop_owner_unlock", snap_ready, 2'b01);
      set_req(2'b11, 2'b00, 1'b1);
      cycle();
      chk("drop_then_other", snap_ready, 2'b10);
      drain();

      // asynchronous reset while locked with 3 outstanding
      hold_resp = 1;
      for (int t = 0; t < 3; t++) begin
         set_req(2'b01, 2'b01, 1'b1);
         cycle();
      end
      set_req(2'b11, 2'b00, 1'b1);
      for (int i = 0; i < N; i++) req_pkt_i[i*PW +: PW] = pkt_a[i];
      #1 chk("pre_reset_v", v_o, 1);
      #1 reset_n_i = 1'b0;
      #1;
      chk("midreset_v_o", v_o, 0);
      chk("midreset_ready", req_ready_and_o, 0);
      chk("midreset_yumi", yumi_o, 0);
      req_v_i = '0;
      #1 reset_n_i = 1'b1;
      model_reset();
      hold_resp = 0;
      @(negedge clk_i);
      cyc++;
      set_req(2'b11, 2'b00, 1'b1);
      cycle();
      chk("postreset_grant0", snap_ready, 2'b01);

      // randomized traffic
      yumi_mode = 2;
      for (int t = 0; t < 3000; t++) begin
         set_req(N'($urandom), N'($urandom) & N'($urandom), ($urandom_range(3) != 0));
         hold_resp = ($urandom_range(7) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
